// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode, state, mode and flag types for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op_t'(op) == OP_MUL) || (op_t'(op) == OP_DIV) || (op_t'(op) == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_muldiv
// Description : One-bit-per-cycle shift-add multiplier / restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

    logic             r_busy;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_m;
    mode_t            r_mode;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;

    assign w_sum   = {1'b0, r_hi} + {1'b0, r_m};
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_m};

    // lo/hi expose the value after the current step, so the caller can
    // capture the final result on the same edge as the last iteration.
    always_comb begin
        w_lo_nxt = r_lo;
        w_hi_nxt = r_hi;
        if (r_mode == MODE_MUL) begin
            if (r_lo[0]) begin
                w_hi_nxt = w_sum[WIDTH:1];
                w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
            end else begin
                w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
                w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
            end
        end else if (!w_trial[WIDTH]) begin
            w_hi_nxt = w_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_hi_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    assign lo   = w_lo_nxt;
    assign hi   = w_hi_nxt;
    assign done = r_busy && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_m    <= '0;
            r_mode <= MODE_MUL;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= c_last;
            r_lo   <= A;
            r_hi   <= '0;
            r_m    <= B;
            r_mode <= mode;
        end else if (r_busy) begin
            r_lo <= w_lo_nxt;
            r_hi <= w_hi_nxt;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Valid/ready sequential ALU, single-cycle logic ops, iterative mul/div/mod.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             err
);

    state_t           r_state;
    flags_t           r_flags;
    logic [3:0]       r_op;
    logic             r_bz;

    logic             w_accept;
    logic             w_iter;
    logic             w_done;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic [WIDTH-1:0] w_it_y;
    logic             w_it_c;
    logic             w_it_v;
    logic             w_it_err;

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] y, input logic c, input logic v);
        flags_t f;
        f.n = y[WIDTH-1];
        f.z = (y == '0);
        f.c = c;
        f.v = v;
        return f;
    endfunction

    assign w_accept = (r_state == IDLE) && in_valid && in_ready;
    assign w_iter   = is_iterative(op);

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && w_iter),
        .mode  ((op_t'(op) == OP_MUL) ? MODE_MUL : MODE_DIV),
        .A     (A),
        .B     (B),
        .lo    (w_lo),
        .hi    (w_hi),
        .done  (w_done)
    );

    // Extra top bit carries out of add/shl; the shr guard bit below bit 0
    // catches the last bit shifted out. Over-range amounts fall out as zero.
    assign w_add = {1'b0, A} + {1'b0, B};
    assign w_sub = {1'b0, A} - {1'b0, B};
    assign w_shl = {1'b0, A} << B;
    assign w_shr = {A, 1'b0} >> B;

    always_comb begin
        w_y   = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                w_y = w_add[WIDTH-1:0];
                w_c = w_add[WIDTH];
                w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_y = w_sub[WIDTH-1:0];
                w_c = ~w_sub[WIDTH];
                w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL, OP_DIV, OP_MOD: w_y = '0;
            OP_AND: w_y = A & B;
            OP_OR:  w_y = A | B;
            OP_XOR: w_y = A ^ B;
            OP_SHL: begin
                w_y = w_shl[WIDTH-1:0];
                w_c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_y = w_shr[WIDTH:1];
                w_c = w_shr[0];
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_it_y   = w_hi;
        w_it_c   = 1'b0;
        w_it_v   = r_bz;
        w_it_err = r_bz;
        case (op_t'(r_op))
            OP_MUL: begin
                w_it_y   = w_lo;
                w_it_c   = (w_hi != '0);
                w_it_v   = (w_hi != '0);
                w_it_err = 1'b0;
            end
            OP_DIV:  w_it_y = w_lo;
            default: w_it_y = w_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            Y         <= '0;
            r_flags   <= '0;
            err       <= 1'b0;
            r_op      <= '0;
            r_bz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (w_accept) begin
                        in_ready <= 1'b0;
                        r_op     <= op;
                        r_bz     <= (B == '0);
                        if (w_iter) begin
                            r_state <= CALC;
                        end else begin
                            Y         <= w_y;
                            r_flags   <= mk_flags(w_y, w_c, w_v);
                            err       <= w_err;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                CALC: begin
                    if (w_done) begin
                        Y         <= w_it_y;
                        r_flags   <= mk_flags(w_it_y, w_it_c, w_it_v);
                        err       <= w_it_err;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign N = r_flags.n;
    assign Z = r_flags.z;
    assign C = r_flags.c;
    assign V = r_flags.v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed + random checks of alu_seq against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam longint c_smax = 64'sd2147483647;
    localparam longint c_smin = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        N;
    logic        Z;
    logic        C;
    logic        V;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input int o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] y, output logic c, output logic v,
                                      output logic e);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        y = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (o)
            0: begin
                p = {32'b0, a} + {32'b0, b};
                y = p[31:0];
                c = p[32];
                r = sa + sb;
                v = (r > c_smax) || (r < c_smin);
            end
            1: begin
                y = a - b;
                c = (a >= b);
                r = sa - sb;
                v = (r > c_smax) || (r < c_smin);
            end
            2: begin
                p = 64'(a) * 64'(b);
                y = p[31:0];
                c = (p[63:32] != 0);
                v = c;
            end
            3: if (b == 0) begin y = '1; e = 1'b1; v = 1'b1; end else y = a / b;
            4: if (b == 0) begin y = a;  e = 1'b1; v = 1'b1; end else y = a % b;
            5: y = a & b;
            6: y = a | b;
            7: y = a ^ b;
            8: begin
                y = (b >= 32) ? 32'd0 : (a << b);
                if (b != 0 && b <= 32) c = a[32 - b];
            end
            9: begin
                y = (b >= 32) ? 32'd0 : (a >> b);
                if (b != 0 && b <= 32) c = a[b - 1];
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        ok = in_ready;
        if (!ok) check("in_ready_wait", in_ready, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        bit          ok;
        int          lat;
        logic [31:0] ey;
        logic        ec;
        logic        ev;
        logic        ee;
        wait_ready(ok);
        if (!ok) return;
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; op = 4'($urandom);
        wait_out(lat);
        ref_model(int'(o), a, b, ey, ec, ev, ee);
        check($sformatf("op%0d latency", o), lat, (o >= 2 && o <= 4) ? 33 : 1);
        check($sformatf("op%0d Y a=%h b=%h", o, a, b), Y, ey);
        check($sformatf("op%0d NZCV a=%h b=%h", o, a, b), {N, Z, C, V}, {ey[31], ey == 0, ec, ev});
        check($sformatf("op%0d err", o), err, ee);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          seen;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; op = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset in_ready low", in_ready, 0);
        @(posedge clk); #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset Y", Y, 0);
        check("reset flags", {N, Z, C, V}, 4'b0000);
        check("reset err", err, 0);

        run_op(4'd0, 32'h7FFF_FFFF, 32'd1);
        run_op(4'd1, 32'd5, 32'd5);
        run_op(4'd1, 32'd3, 32'd5);
        run_op(4'd2, 32'h0001_0000, 32'h0001_0000);
        run_op(4'd3, 32'd100, 32'd7);
        run_op(4'd4, 32'd100, 32'd7);
        run_op(4'd3, 32'd9, 32'd0);
        run_op(4'd4, 32'd9, 32'd0);
        run_op(4'd8, 32'h8000_0001, 32'd1);
        run_op(4'd9, 32'hDEAD_BEEF, 32'd40);
        run_op(4'd8, 32'h1234_5679, 32'd32);
        run_op(4'd9, 32'h9234_5678, 32'd32);
        run_op(4'd12, 32'h1111_2222, 32'h3333_4444);

        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 40);
                1: b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op(o, a, b);
        end

        // Backpressure: result must hold and no new op may slip in.
        wait_ready(ok);
        out_ready = 1'b0;
        op = 4'd0; A = 32'd3; B = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 4'd1; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            check("bp Y", Y, 32'd7);
            check("bp flags", {N, Z, C, V}, 4'b0000);
            check("bp in_ready", in_ready, 0);
            check("bp out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", out_valid, 0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("bp no extra op", seen, 0);

        // Reset in the middle of a multiply aborts it silently.
        wait_ready(ok);
        op = 4'd2; A = $urandom | 32'd1; B = $urandom | 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        rst_n = 1'b1;
        check("abort in_ready low", in_ready, 0);
        @(posedge clk); #1;
        check("abort in_ready", in_ready, 1);
        check("abort Y", Y, 0);
        check("abort flags", {N, Z, C, V}, 4'b0000);
        check("abort err", err, 0);
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("abort no output", seen, 0);

        run_op(4'd3, 32'd100, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
